hilo_muldiv_unit: RTL and testbench
===================================

# hilo_muldiv_unit

Iterative multi-cycle multiply/divide engine that produces the HI/LO results for MULT, MULTU, DIV and DIVU. It is the writer side of the register file's HI/LO write port: `hi_write`, `lo_write`, `hi_data` and `lo_data` connect directly to that port. The decode/execute stage drives `start`, and holds any instruction that reads HI or LO while `busy` is high.

## Interface

Parameters:
- `WIDTH`, default 32: operand width. Internal iteration count equals `WIDTH`. All values in this document assume 32.

Ports (clock and reset first):
- `clk`  in  1: clock.
- `reset`  in  1: reset, asynchronous, active-high.
- `start`  in  1: request pulse. Sampled only in IDLE.
- `op`  in  2: operation. 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `rs`  in  WIDTH: multiplicand or dividend. Sampled with `start`.
- `rt`  in  WIDTH: multiplier or divisor. Sampled with `start`.
- `busy`  out  1: operation in flight. High in every state except IDLE.
- `done`  out  1: one-cycle completion pulse.
- `hi_write`  out  1: HI write strobe to the register file.
- `lo_write`  out  1: LO write strobe to the register file.
- `hi_data`  out  WIDTH: HI result. Product bits [63:32], or remainder.
- `lo_data`  out  WIDTH: LO result. Product bits [31:0], or quotient.

## Operation

States: IDLE → RUN → FIX → WB → IDLE.

- **IDLE**
  - When `start` = 1 at a clock edge: latch `op`, |rs| and |rt| (unsigned ops take raw values), the result signs, a divide-by-zero flag and a signed-overflow flag.
  - Clear the accumulators, set iteration count = 0, go to RUN.
- **RUN**, exactly `WIDTH` cycles, one bit per cycle:
  - Multiply: shift-add on a 2·WIDTH-bit accumulator.
  - Divide: restoring shift-subtract. Each cycle produces one quotient bit; the remainder is held at WIDTH+1 bits.
  - When count reaches WIDTH−1, go to FIX.
- **FIX**, one cycle: apply the sign correction and special cases, then register the final values into `hi_data`/`lo_data`.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: quotient truncates toward zero. Negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Divide by zero (rt = 0), both DIV and DIVU: LO = 0xFFFFFFFF, HI = original rs.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- **WB**, one cycle: `hi_write` = `lo_write` = `done` = 1, then go to IDLE.

Rules:
- `start` is ignored while `busy` = 1, including in the WB cycle. It is not queued.
- `hi_data`/`lo_data` change only on the FIX→WB edge. They hold their value until the next FIX.
- `rs`/`rt`/`op` are don't-care after the start edge.

## Timing

- Reset values: `busy`, `done`, `hi_write`, `lo_write` = 0; `hi_data`, `lo_data` = 0; state = IDLE; count = 0.
- Let E0 be the edge that samples `start`.
  - RUN covers the 32 cycles after edges E0..E31.
  - FIX is the cycle after E32.
  - WB is the cycle after E33.
  - Fixed latency: strobes are high in the 34th cycle after E0, and the register file captures on E34.
  - The latency is identical for all ops and for the special cases.
- `busy` rises in the cycle after E0. It falls after E34 with IDLE, so it is low in the cycle after E34.
- The earliest back-to-back `start` is sampled at E35, which gives a throughput of one op per 35 cycles.
- `start` = 1 held continuously: a new op begins at every IDLE edge.
- Reset asserted mid-operation: everything returns immediately to the reset values.
  - No strobe is issued, including when reset lands in the WB cycle.
  - Operation resumes normally on the first edge after release.

## Test plan

1. MULTU rs = 0xFFFFFFFF, rt = 0xFFFFFFFF → hi_data = 0xFFFFFFFE, lo_data = 0x00000001. `hi_write`/`lo_write`/`done` high for exactly one cycle, 34 cycles after the start edge. `busy` high for 34 cycles.
2. MULT rs = 0xFFFFFFFD (−3), rt = 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
3. DIV rs = 0xFFFFFFF9 (−7), rt = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 2 → LO = 3, HI = 1. DIV 7 / −2 → LO = 0xFFFFFFFD, HI = 1.
4. Special cases:
   - DIVU 5 / 0 → LO = 0xFFFFFFFF, HI = 5.
   - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
   - Same 34-cycle latency in both cases.
5. Handshake:
   - Pulse `start` (MULTU 2 × 3) again at cycles 5 and 34 after the first start → both ignored; exactly one `done`, with LO = 6.
   - Hold `start` high with DIVU 9 / 3 → successive results LO = 3, HI = 0, starts sampled at a 35-cycle spacing.
6. Reset mid-operation:
   - Reset asserted at cycle 10 of an op → `busy` = 0 with no strobe.
   - A new MULTU 4 × 4 after release → LO = 16, 34 cycles later.
   - Reset asserted during WB → no strobe observed.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine driving the HI/LO write port.
//   clk, reset (async, active-high)
//   start, op[1:0] (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), rs, rt : request, sampled in IDLE
//   busy : op in flight; done, hi_write, lo_write : one-cycle writeback pulse
//   hi_data, lo_data : product high/low, or remainder/quotient
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic             hi_write,
    output logic             lo_write,
    output logic [WIDTH-1:0] hi_data,
    output logic [WIDTH-1:0] lo_data
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, RUN, FIX, WB} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, rs_q, rs_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic               dbz_q, dbz_d, ovf_q, ovf_d;
    logic               busy_q, busy_d, strobe_q, strobe_d;
    logic [WIDTH-1:0]   hi_data_q, hi_data_d, lo_data_q, lo_data_d;
    logic               rs_neg, rt_neg;
    logic [WIDTH:0]     psum;
    logic [WIDTH+1:0]   shifted, diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rs_d      = rs_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        strobe_d  = 1'b0;
        hi_data_d = hi_data_q;
        lo_data_d = lo_data_q;
        rs_neg    = ~op[0] & rs[WIDTH-1];
        rt_neg    = ~op[0] & rt[WIDTH-1];
        // Right-shifting multiply: add the multiplicand into the top half, shift the pair right.
        psum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q & {WIDTH{b_q[0]}}};
        // Restoring divide: a_q shifts the dividend out at the top and quotient bits in at the bottom.
        // A negative trial difference shows up as the top bit of the wrapped result.
        shifted   = {rem_q, a_q[WIDTH-1]};
        diff      = shifted - {2'b00, b_q};
        prod_fix  = neg_res_q ? -acc_q : acc_q;
        quo_fix   = neg_res_q ? -a_q : a_q;
        rem_fix   = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        case (state_q)
            IDLE: if (start) begin
                state_d   = RUN;
                count_d   = '0;
                op_d      = op;
                a_d       = rs_neg ? -rs : rs;
                b_d       = rt_neg ? -rt : rt;
                rs_d      = rs;
                acc_d     = '0;
                rem_d     = '0;
                neg_res_d = rs_neg ^ rt_neg;
                neg_rem_d = rs_neg;
                dbz_d     = op[1] && rt == '0;
                ovf_d     = op == 2'b10 && rs == MIN_NEG && rt == '1;
                busy_d    = 1'b1;
            end
            RUN: begin
                if (op_q[1]) begin
                    rem_d = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
                    a_d   = {a_q[WIDTH-2:0], ~diff[WIDTH+1]};
                end else begin
                    acc_d = {psum, acc_q[WIDTH-1:1]};
                    b_d   = b_q >> 1;
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH-1)) state_d = FIX;
            end
            FIX: begin
                state_d   = WB;
                strobe_d  = 1'b1;
                hi_data_d = dbz_q ? rs_q : ovf_q ? '0 : op_q[1] ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                lo_data_d = dbz_q ? '1 : ovf_q ? MIN_NEG : op_q[1] ? quo_fix : prod_fix[WIDTH-1:0];
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rs_q      <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            strobe_q  <= 1'b0;
            hi_data_q <= '0;
            lo_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rs_q      <= rs_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            strobe_q  <= strobe_d;
            hi_data_q <= hi_data_d;
            lo_data_q <= lo_data_d;
        end
    end
    assign busy     = busy_q;
    assign done     = strobe_q;
    assign hi_write = strobe_q;
    assign lo_write = strobe_q;
    assign hi_data  = hi_data_q;
    assign lo_data  = lo_data_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: random and directed checks of hilo_muldiv_unit against a cycle-level reference model.
module tb_hilo_muldiv_unit;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] rs = '0, rt = '0;
    logic        busy, done, hi_write, lo_write;
    logic [31:0] hi_data, lo_data;
    int          vecs = 0, errs = 0;
    int          age = 0;
    logic [63:0] pend = '0, exp_res = '0;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
        .busy(busy), .done(done), .hi_write(hi_write), .lo_write(lo_write),
        .hi_data(hi_data), .lo_data(lo_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_res(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'h0, a};
        logic [63:0] ub = {32'h0, b};
        if (o[1] && b == 32'h0) return {a, 32'hFFFFFFFF};
        if (o == 2'b10 && a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        case (o)
            2'b00:   return 64'(sa * sb);
            2'b01:   return ua * ub;
            2'b10:   return {32'(sa % sb), 32'(sa / sb)};
            default: return {32'(ua % ub), 32'(ua / ub)};
        endcase
    endfunction

    // age = cycles since the accepted start (0 = idle); result appears when age reaches 34.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            age     <= 0;
            exp_res <= '0;
        end else if (age == 0) begin
            if (start) begin
                age  <= 1;
                pend <= ref_res(op, rs, rt);
            end
        end else begin
            age <= (age == 34) ? 0 : age + 1;
            if (age == 33) exp_res <= pend;
        end
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(age >= 1));
        chk("done", 64'(done), 64'(age == 34));
        chk("hi_write", 64'(hi_write), 64'(age == 34));
        chk("lo_write", 64'(lo_write), 64'(age == 34));
        chk("hi_data", 64'(hi_data), 64'(exp_res[63:32]));
        chk("lo_data", 64'(lo_data), 64'(exp_res[31:0]));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return $urandom_range(15);
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e, input string nm);
        int lat = 0, bcnt = 0;
        op = o; rs = a; rt = b; start = 1'b1;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            step();
            if (n == 1) begin
                start = 1'b0; op = 2'($urandom); rs = $urandom; rt = $urandom;
            end
            if (busy) bcnt++;
            if (done) lat = n;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd34);
        chk({nm, "_busy_cycles"}, 64'(bcnt), 64'd34);
        chk({nm, "_result"}, {hi_data, lo_data}, e);
        step();
    endtask

    initial begin
        int dn, k;
        int t[4];
        repeat (3) step();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_strobes", 64'({done, hi_write, lo_write}), 64'd0);
        chk("reset_data", {hi_data, lo_data}, 64'd0);
        reset = 1'b0;
        step();

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "multu_max");
        run_op(2'b00, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, "mult_neg");
        run_op(2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, "mult_min");
        run_op(2'b10, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, "div_neg_dividend");
        run_op(2'b11, 32'd7,        32'd2,        64'h00000001_00000003, "divu_7_2");
        run_op(2'b10, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "div_neg_divisor");
        run_op(2'b11, 32'd5,        32'd0,        64'h00000005_FFFFFFFF, "divu_by_zero");
        run_op(2'b10, 32'hFFFFFFF0, 32'd0,        64'hFFFFFFF0_FFFFFFFF, "div_by_zero");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_overflow");

        // Starts during RUN and during WB must be dropped.
        op = 2'b01; rs = 32'd2; rt = 32'd3; start = 1'b1; dn = 0;
        for (int n = 1; n <= 80; n++) begin
            step();
            if (done) begin
                dn++;
                if (dn == 1) chk("hs_lo", 64'(lo_data), 64'd6);
            end
            start = (n == 5 || n == 34);
            if (start) begin rs = 32'd7; rt = 32'd7; end
        end
        chk("hs_done_count", 64'(dn), 64'd1);

        // Held start: back-to-back ops every 35 cycles.
        op = 2'b11; rs = 32'd9; rt = 32'd3; start = 1'b1; k = 0;
        for (int n = 1; n <= 110; n++) begin
            step();
            if (done) begin
                if (k < 4) t[k] = n;
                k++;
                chk("hold_result", {hi_data, lo_data}, 64'h00000000_00000003);
            end
        end
        start = 1'b0;
        chk("hold_done_count", 64'(k), 64'd3);
        chk("hold_spacing_1", 64'(t[1] - t[0]), 64'd35);
        chk("hold_spacing_2", 64'(t[2] - t[1]), 64'd35);
        repeat (40) step();

        // Reset at cycle 10 of an op.
        op = 2'b01; rs = 32'd5; rt = 32'd5; start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (n == 1) start = 1'b0;
        end
        reset = 1'b1;
        step();
        chk("mid_reset_busy", 64'(busy), 64'd0);
        step();
        reset = 1'b0;
        dn = 0;
        repeat (40) begin step(); if (done || hi_write || lo_write) dn++; end
        chk("mid_reset_no_strobe", 64'(dn), 64'd0);
        run_op(2'b01, 32'd4, 32'd4, 64'h00000000_00000010, "after_reset");

        // Reset landing in the WB cycle.
        op = 2'b01; rs = 32'd3; rt = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (33) @(posedge clk);
        #1 reset = 1'b1;
        step();
        chk("wb_reset_strobes", 64'({done, hi_write, lo_write}), 64'd0);
        chk("wb_reset_data", {hi_data, lo_data}, 64'd0);
        step();
        reset = 1'b0;
        dn = 0;
        repeat (40) begin step(); if (done) dn++; end
        chk("wb_reset_no_done", 64'(dn), 64'd0);

        // Random traffic with corner operands, stray starts and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            step();
            reset = ($urandom_range(400) == 0);
            start = ($urandom_range(3) == 0);
            op = 2'($urandom);
            rs = pick();
            rt = pick();
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
